stopwatch_time_counter: RTL and testbench
=========================================

# stopwatch_time_counter

Stopwatch time-keeping datapath directly downstream of the stopwatch control block. It holds four cascaded wrap-around fields: milliseconds, seconds, minutes and hours. Each field steps on the up/down strobes it receives, and the block returns same-cycle carry-up pulses that the control block gates into the next field's up strobe. The field values also drive the display path, optionally through a lap-hold register.

## Interface
- MS_MAX, 999, top value of the millisecond field; width MS_W = clog2(MS_MAX+1) = 10.
- SEC_MAX, 59, top value of the second field; width 6.
- MIN_MAX, 59, top value of the minute field; width 6.
- HR_MAX, 99, top value of the hour field; width HR_W = 7.
- i_clk  input  1  clock.
- i_rstn  input  1  reset, asynchronous, active-low.
- i_ms_up / i_ms_down  input  1 each  millisecond field step strobes.
- i_sec_up / i_sec_down  input  1 each  second field step strobes.
- i_min_up / i_min_down  input  1 each  minute field step strobes.
- i_hr_up / i_hr_down  input  1 each  hour field step strobes.
- i_lap  input  1  lap toggle request; present only with STOPWATCH_LAP_EN.
- o_ms  output  MS_W  live millisecond value.
- o_sec / o_min  output  6 each  live second and minute values.
- o_hr  output  HR_W  live hour value.
- o_ms_carryup, o_sec_carryup, o_min_carryup, o_hr_carryup  output  1 each  combinational wrap pulses.
- o_disp_ms, o_disp_sec, o_disp_min, o_disp_hr  output  same widths as the live values  display values.
- o_lap_active  output  1  lap hold in force; tied 0 without STOPWATCH_LAP_EN.

## Operation
- Each field is a register. Per rising clock edge it applies the first matching rule below:
  - up=1, down=1: clear the field to 0. This is the control block's set/clear encoding.
  - up=1, down=0: if value==MAX, load 0; otherwise add 1.
  - up=0, down=1: if value==0, load MAX; otherwise subtract 1. No borrow is produced.
  - up=0, down=0: hold.
- Carry-up pulse: carryup = up & ~down & (value==MAX). It is purely combinational from the current register value and the strobes.
- A clear (up and down together) never raises carryup, even when value==MAX.
- Carries ripple in the same cycle, from ms_carryup through the control block into sec_up, and so on up the chain. There is no combinational loop, because each field's carry depends only on its own strobes.
- o_hr_carryup marks the 99:59:59.999 to 0 rollover. It is an output only; nothing consumes it internally.
- Values never exceed MAX. Arithmetic is unsigned at the field width, with the compare done before the increment, so overflow is impossible.

## Timing
- Reset value of every output: all field registers 0, all carryups 0, all display outputs 0, o_lap_active 0.
- Step latency: a strobe in cycle N changes the value at the edge ending cycle N, so the new value is visible in cycle N+1.
- Carry latency: 0 cycles, because carryup is valid in the same cycle as the strobe. A full cascade therefore updates every field on one edge.
- Reset asserted mid-operation clears all fields immediately, without waiting for the clock. On release, the first edge with strobes resumes counting from 0.
- Strobes are level-sampled once per clock. A strobe held high for k cycles steps the field k times.

## Configuration
- STOPWATCH_LAP_EN defined:
  - Adds i_lap and a 2-state FSM with states LIVE and HOLD.
  - A rising edge of i_lap is detected with a 1-flop delay. In LIVE it captures all four live values into the display registers and moves to HOLD. In HOLD it returns to LIVE.
  - In HOLD, o_disp_* show the captured values and o_lap_active=1.
  - In LIVE, o_disp_* equal the live values.
  - The live counters keep running in both states.
  - A clear on all four fields (every up&down asserted together) forces the FSM to LIVE.
  - Reset forces LIVE and zeroes the captures.
- STOPWATCH_LAP_EN undefined: o_disp_* are wired to the live values, o_lap_active=0, the i_lap port is absent, and no lap flops are present.

## Structure
- Shared package stopwatch_pkg holds:
  - MS_MAX, SEC_MAX, MIN_MAX, HR_MAX defaults;
  - derived widths;
  - the lap FSM state enum (LIVE, HOLD).
- Sub-module stopwatch_field_counter, parameterised by MAX and W, holds one register plus its carryup logic. It is instanced four times.
- The top level contains only the instances plus the lap logic.

## Test plan
- Reset, then i_ms_up for 1000 cycles -> o_ms counts 0..999 then back to 0, and o_ms_carryup is high only in the cycle with o_ms==999.
- Preload to 99:59:59.999 via down strobes from 0, then one up on every field gated by carries -> all fields 0 on the next edge and all four carryups high in that cycle.
- o_sec=0 with i_sec_down=1 -> o_sec=59; o_min unchanged; no carryup.
- o_min=59 with i_min_up=1 and i_min_down=1 -> o_min=0 and o_min_carryup=0.
- i_rstn pulsed low between clock edges with o_ms=500 -> o_ms=0 immediately, before the next edge.
- With LAP_EN, at o_ms=123: pulse i_lap, run 10 cycles, pulse i_lap again -> o_disp_ms holds 123 with o_lap_active=1 during those cycles, then follows o_ms=133 live.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch time-keeping datapath.
// Field limits, derived widths and the lap-hold state encoding live here.
package stopwatch_pkg;

  localparam int MS_MAX  = 999;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 99;

  localparam int MS_W  = $clog2(MS_MAX + 1);
  localparam int SEC_W = $clog2(SEC_MAX + 1);
  localparam int MIN_W = $clog2(MIN_MAX + 1);
  localparam int HR_W  = $clog2(HR_MAX + 1);

  typedef enum logic {
    LIVE = 1'b0,
    HOLD = 1'b1
  } lap_state_e;

endpackage

// File: rtl/stopwatch_field_counter.sv
// One wrap-around time field: up/down stepping, up+down clear, and a
// same-cycle carry-up pulse raised when an up step wraps MAX back to 0.
module stopwatch_field_counter #(
  parameter int MAX = 59,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_up,
  input  logic         i_down,
  output logic [W-1:0] o_value,
  output logic         o_carryup
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] value;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      value <= '0;
    end else begin
      unique case ({i_up, i_down})
        2'b11:   value <= '0;
        2'b10:   value <= (value == MAX_V) ? '0 : value + W'(1);
        2'b01:   value <= (value == '0) ? MAX_V : value - W'(1);
        default: value <= value;
      endcase
    end
  end

  // A clear (up and down together) must never look like a wrap.
  assign o_carryup = i_up & ~i_down & (value == MAX_V);
  assign o_value   = value;

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch ms/sec/min/hr datapath with carry-up outputs for the control block.
// Optional lap-hold display register enabled by defining STOPWATCH_LAP_EN.
module stopwatch_time_counter
  import stopwatch_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
`ifdef STOPWATCH_LAP_EN
  input  logic             i_lap,
`endif
  input  logic             i_ms_up,
  input  logic             i_ms_down,
  input  logic             i_sec_up,
  input  logic             i_sec_down,
  input  logic             i_min_up,
  input  logic             i_min_down,
  input  logic             i_hr_up,
  input  logic             i_hr_down,
  output logic [MS_W-1:0]  o_ms,
  output logic [SEC_W-1:0] o_sec,
  output logic [MIN_W-1:0] o_min,
  output logic [HR_W-1:0]  o_hr,
  output logic             o_ms_carryup,
  output logic             o_sec_carryup,
  output logic             o_min_carryup,
  output logic             o_hr_carryup,
  output logic [MS_W-1:0]  o_disp_ms,
  output logic [SEC_W-1:0] o_disp_sec,
  output logic [MIN_W-1:0] o_disp_min,
  output logic [HR_W-1:0]  o_disp_hr,
  output logic             o_lap_active
);

  stopwatch_field_counter #(.MAX(MS_MAX), .W(MS_W)) u_ms (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_up      (i_ms_up),
    .i_down    (i_ms_down),
    .o_value   (o_ms),
    .o_carryup (o_ms_carryup)
  );

  stopwatch_field_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_up      (i_sec_up),
    .i_down    (i_sec_down),
    .o_value   (o_sec),
    .o_carryup (o_sec_carryup)
  );

  stopwatch_field_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_up      (i_min_up),
    .i_down    (i_min_down),
    .o_value   (o_min),
    .o_carryup (o_min_carryup)
  );

  stopwatch_field_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_up      (i_hr_up),
    .i_down    (i_hr_down),
    .o_value   (o_hr),
    .o_carryup (o_hr_carryup)
  );

`ifdef STOPWATCH_LAP_EN
  lap_state_e       state, next_state;
  logic             lap_q;
  logic             lap_rise;
  logic             clear_all;
  logic             capture;
  logic [MS_W-1:0]  cap_ms;
  logic [SEC_W-1:0] cap_sec;
  logic [MIN_W-1:0] cap_min;
  logic [HR_W-1:0]  cap_hr;

  assign lap_rise  = i_lap & ~lap_q;
  assign clear_all = i_ms_up & i_ms_down & i_sec_up & i_sec_down &
                     i_min_up & i_min_down & i_hr_up & i_hr_down;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= LIVE;
      lap_q <= 1'b0;
    end else begin
      state <= next_state;
      lap_q <= i_lap;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    if (clear_all) begin
      next_state = LIVE;
    end else if (lap_rise) begin
      unique case (state)
        LIVE: begin
          capture    = 1'b1;
          next_state = HOLD;
        end
        HOLD:    next_state = LIVE;
        default: next_state = LIVE;
      endcase
    end
  end

  // Captures are plain registers, so resetting them to 0 is cheap and keeps
  // the display defined out of reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cap_ms  <= '0;
      cap_sec <= '0;
      cap_min <= '0;
      cap_hr  <= '0;
    end else if (capture) begin
      cap_ms  <= o_ms;
      cap_sec <= o_sec;
      cap_min <= o_min;
      cap_hr  <= o_hr;
    end
  end

  assign o_lap_active = (state == HOLD);
  assign o_disp_ms    = o_lap_active ? cap_ms  : o_ms;
  assign o_disp_sec   = o_lap_active ? cap_sec : o_sec;
  assign o_disp_min   = o_lap_active ? cap_min : o_min;
  assign o_disp_hr    = o_lap_active ? cap_hr  : o_hr;
`else
  assign o_lap_active = 1'b0;
  assign o_disp_ms    = o_ms;
  assign o_disp_sec   = o_sec;
  assign o_disp_min   = o_min;
  assign o_disp_hr    = o_hr;
`endif

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Self-checking bench for stopwatch_time_counter: directed vector table,
// hand-written corner sequences and randomized strobes against a field model.
module tb_stopwatch_time_counter;
  import stopwatch_pkg::*;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [3:0]       up = '0;   // {hr, min, sec, ms}
  logic [3:0]       dn = '0;
  logic             lap = 1'b0;
  logic [MS_W-1:0]  o_ms, o_disp_ms;
  logic [SEC_W-1:0] o_sec, o_disp_sec;
  logic [MIN_W-1:0] o_min, o_disp_min;
  logic [HR_W-1:0]  o_hr, o_disp_hr;
  logic             o_ms_c, o_sec_c, o_min_c, o_hr_c, o_lap_active;

  stopwatch_time_counter dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
`ifdef STOPWATCH_LAP_EN
    .i_lap         (lap),
`endif
    .i_ms_up       (up[0]),
    .i_ms_down     (dn[0]),
    .i_sec_up      (up[1]),
    .i_sec_down    (dn[1]),
    .i_min_up      (up[2]),
    .i_min_down    (dn[2]),
    .i_hr_up       (up[3]),
    .i_hr_down     (dn[3]),
    .o_ms          (o_ms),
    .o_sec         (o_sec),
    .o_min         (o_min),
    .o_hr          (o_hr),
    .o_ms_carryup  (o_ms_c),
    .o_sec_carryup (o_sec_c),
    .o_min_carryup (o_min_c),
    .o_hr_carryup  (o_hr_c),
    .o_disp_ms     (o_disp_ms),
    .o_disp_sec    (o_disp_sec),
    .o_disp_min    (o_disp_min),
    .o_disp_hr     (o_disp_hr),
    .o_lap_active  (o_lap_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each field is an integer modulo (MAX+1).
  int mx[4] = '{MS_MAX, SEC_MAX, MIN_MAX, HR_MAX};
  int v[4];
  int cap[4];
  bit hold;
  bit lap_prev;

  typedef struct {
    logic [3:0] up;
    logic [3:0] dn;
    logic [3:0] c;
    int         ms, sec, mn, hr;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int live(input int i);
    case (i)
      0:       return int'(o_ms);
      1:       return int'(o_sec);
      2:       return int'(o_min);
      default: return int'(o_hr);
    endcase
  endfunction

  function automatic int disp(input int i);
    case (i)
      0:       return int'(o_disp_ms);
      1:       return int'(o_disp_sec);
      2:       return int'(o_disp_min);
      default: return int'(o_disp_hr);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      v[i]   = 0;
      cap[i] = 0;
    end
    hold     = 1'b0;
    lap_prev = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_val"}, live(i), v[i]);
      check({tag, "_disp"}, disp(i), hold ? cap[i] : v[i]);
    end
    check({tag, "_lap_active"}, int'(o_lap_active), int'(hold));
  endtask

  // One clock cycle. With gate set, each field's up strobe is also raised by
  // the model's carry of the field below, as the control block would do.
  task automatic step(input logic [3:0] u, input logic [3:0] d, input bit gate,
                      input bit l, output logic [3:0] seen_c);
    logic [3:0] uu;
    logic [3:0] ec;
    uu = u;
    ec = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (gate && i > 0 && ec[i-1]) uu[i] = 1'b1;
      ec[i] = uu[i] & ~d[i] & (v[i] == mx[i]);
    end
    up  = uu;
    dn  = d;
    lap = l;
    #1;
    seen_c = {o_hr_c, o_min_c, o_sec_c, o_ms_c};
    check("carryup", int'(seen_c), int'(ec));
    @(posedge clk);
    if (&(uu & d)) hold = 1'b0;
    else if (l && !lap_prev) begin
      if (!hold) begin
        for (int i = 0; i < 4; i++) cap[i] = v[i];
        hold = 1'b1;
      end else begin
        hold = 1'b0;
      end
    end
    lap_prev = l;
    for (int i = 0; i < 4; i++) begin
      if (uu[i] && d[i])  v[i] = 0;
      else if (uu[i])     v[i] = (v[i] + 1) % (mx[i] + 1);
      else if (d[i])      v[i] = (v[i] + mx[i]) % (mx[i] + 1);
    end
    #1;
    check_state("step");
  endtask

  logic [3:0] c;

  initial begin
    // Hand-derived vectors applied in order from the reset state.
    tbl[0]  = '{4'b0000, 4'b0010, 4'b0000,   0, 59,  0,  0}; // sec 0 down -> 59
    tbl[1]  = '{4'b0000, 4'b0100, 4'b0000,   0, 59, 59,  0};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0000,   0, 59,  0,  0}; // clear at MAX, no carry
    tbl[3]  = '{4'b0000, 4'b0100, 4'b0000,   0, 59, 59,  0};
    tbl[4]  = '{4'b0100, 4'b0000, 4'b0100,   0, 59,  0,  0}; // min wrap
    tbl[5]  = '{4'b0000, 4'b1000, 4'b0000,   0, 59,  0, 99};
    tbl[6]  = '{4'b1000, 4'b0000, 4'b1000,   0, 59,  0,  0}; // hr wrap
    tbl[7]  = '{4'b0000, 4'b0001, 4'b0000, 999, 59,  0,  0};
    tbl[8]  = '{4'b0011, 4'b0000, 4'b0011,   0,  0,  0,  0}; // ms+sec wrap together
    tbl[9]  = '{4'b0001, 4'b0000, 4'b0000,   1,  0,  0,  0};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000,   1,  0,  0,  0}; // hold
    tbl[11] = '{4'b1111, 4'b1111, 4'b0000,   0,  0,  0,  0}; // clear all

    model_reset();
    #12;
    check("reset_carry", int'({o_hr_c, o_min_c, o_sec_c, o_ms_c}), 0);
    check_state("reset");
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].up, tbl[k].dn, 1'b0, 1'b0, c);
      check("tbl_carry", int'(c), int'(tbl[k].c));
      check("tbl_ms", int'(o_ms), tbl[k].ms);
      check("tbl_sec", int'(o_sec), tbl[k].sec);
      check("tbl_min", int'(o_min), tbl[k].mn);
      check("tbl_hr", int'(o_hr), tbl[k].hr);
    end

    // Millisecond field counts a full lap and returns to 0.
    for (int k = 0; k < 1000; k++) begin
      step(4'b0001, 4'b0000, 1'b0, 1'b0, c);
      check("ms_run_carry", int'(c[0]), (k == 999) ? 1 : 0);
    end
    check("ms_run_end", int'(o_ms), 0);

    // Preload 99:59:59.999 by stepping down from 0, then one gated cascade.
    step(4'b0000, 4'b1111, 1'b0, 1'b0, c);
    check("preload_hr", int'(o_hr), 99);
    check("preload_ms", int'(o_ms), 999);
    step(4'b0001, 4'b0000, 1'b1, 1'b0, c);
    check("cascade_carries", int'(c), 15);
    check("cascade_zero", int'({o_hr, o_min, o_sec, o_ms}), 0);

    // Randomized strobes, sometimes gated by the model's carries.
    for (int k = 0; k < 3000; k++) begin
      step(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'b0, c);
    end

    // Asynchronous reset between edges with o_ms at 500.
    step(4'b1111, 4'b1111, 1'b0, 1'b0, c);
    for (int k = 0; k < 500; k++) step(4'b0001, 4'b0000, 1'b0, 1'b0, c);
    check("pre_async_ms", int'(o_ms), 500);
    @(negedge clk);
    up = '0;
    dn = '0;
    #2 rstn = 1'b0;
    #1;
    check("async_ms", int'(o_ms), 0);
    model_reset();
    check_state("async");
    @(negedge clk);
    rstn = 1'b1;
    step(4'b0001, 4'b0000, 1'b0, 1'b0, c);
    check("post_reset_ms", int'(o_ms), 1);

`ifdef STOPWATCH_LAP_EN
    // Lap hold at 123 across 10 running cycles, then release to live 133.
    step(4'b1111, 4'b1111, 1'b0, 1'b0, c);
    for (int k = 0; k < 123; k++) step(4'b0001, 4'b0000, 1'b0, 1'b0, c);
    step(4'b0000, 4'b0000, 1'b0, 1'b1, c);
    check("lap_capture", int'(o_disp_ms), 123);
    check("lap_active", int'(o_lap_active), 1);
    for (int k = 0; k < 10; k++) begin
      step(4'b0001, 4'b0000, 1'b0, 1'b0, c);
      check("lap_hold_ms", int'(o_disp_ms), 123);
    end
    step(4'b0000, 4'b0000, 1'b0, 1'b1, c);
    check("lap_release_ms", int'(o_disp_ms), 133);
    check("lap_release_active", int'(o_lap_active), 0);
    // A full clear drops the hold.
    step(4'b0000, 4'b0000, 1'b0, 1'b0, c);
    step(4'b0000, 4'b0000, 1'b0, 1'b1, c);
    check("lap_rehold", int'(o_lap_active), 1);
    step(4'b1111, 4'b1111, 1'b0, 1'b0, c);
    check("lap_clear_live", int'(o_lap_active), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
